regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sequences all writes into the register file's single write port (WE3/A3/WD3).
- Arbitrates round-robin between the ALU and LSU writeback requesters.
- Redirects writes that target R15 to the program counter load path, since R15 is not stored in the register file.
- Keeps a per-register pending-write scoreboard that the decode stage uses to stall on RAW and WAW hazards.

Parameters:
- DATA_W, 32, width of writeback data and PC value
- ADDR_W, 4, register address width (16 architectural registers)
- PC_REG, 15, address that maps to the program counter instead of the register file

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- wb_stall  input  1  freezes arbitration; both requester readies forced low
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- lsu_valid  input  1  LSU writeback request
- lsu_ready  output  1  LSU request accepted this cycle
- lsu_addr  input  ADDR_W  LSU destination register
- lsu_data  input  DATA_W  load data
- issue_valid  input  1  decode marks a destination register as pending
- issue_addr  input  ADDR_W  register being issued
- issue_ready  output  1  issue accepted (destination not already pending)
- rf_we  output  1  to register file WE3
- rf_waddr  output  ADDR_W  to register file A3
- rf_wdata  output  DATA_W  to register file WD3
- pc_load  output  1  one-cycle pulse: load PC with pc_wdata
- pc_wdata  output  DATA_W  new PC value
- pending  output  2**ADDR_W  scoreboard, bit i = write to register i outstanding
- err_orphan  output  1  sticky: a commit targeted a non-pending register

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pc_load=0, pc_wdata=0, pending=0, err_orphan=0.
  - Round-robin pointer last_grant=LSU, so the ALU wins the first contention.
- Reset mid-operation drops any in-flight accepted commit; nothing is written after rst rises.
- Grant logic (combinational, from registered last_grant):
  - wb_stall=1: both readies low.
  - Only one requester valid: that requester is ready.
  - Both valid: the requester not equal to last_grant is ready; the other is held low.
  - At most one handshake (valid&&ready) per cycle. last_grant updates on a handshake only.
- Requesters must hold addr/data stable while valid && !ready.
- Commit latency:
  - A handshake at clock edge N registers the commit.
  - Outputs are asserted for exactly one cycle, between edges N and N+1; the register file writes at edge N+1.
  - Back-to-back handshakes give one commit every cycle with no bubble.
- Commit routing:
  - addr != PC_REG: rf_we=1, rf_waddr=addr, rf_wdata=data, pc_load=0.
  - addr == PC_REG: pc_load=1, pc_wdata=data, rf_we=0.
  - No handshake: rf_we=0 and pc_load=0. rf_waddr, rf_wdata and pc_wdata hold their last values.
- Scoreboard:
  - issue_ready = !pending[issue_addr]. Issue to a pending register is refused (WAW stall).
  - Issue handshake at an edge sets pending[issue_addr].
  - Commit handshake at an edge clears pending[addr].
  - Issue and commit to the same addr in the same cycle: pending is only clear for issue_ready if it was not pending, so the commit is an orphan. Set wins, the bit ends at 1, and err_orphan is set.
  - Issue and commit to different addrs in the same cycle: both take effect.
  - Commit to an addr whose pending bit is 0: the write is still performed, the bit stays 0, and err_orphan goes to 1. It is cleared only by rst.
- PC_REG is tracked in pending like any other register, so branch targets can be scoreboarded.
- Width rules: data is passed through unmodified. No arithmetic is performed on PC (the +8 read offset is the register file/PC's concern).

Test Plan:
- Reset while rf_we=1 and pending=16'h00F0 -> rf_we, pc_load, pending and err_orphan all 0 immediately, with no clock needed.
- Issue addr 3, then the ALU commits addr 3 with data 32'hDEADBEEF -> pending[3] is 1 then 0; rf_we=1, rf_waddr=3, rf_wdata=DEADBEEF for exactly 1 cycle, one cycle after the handshake.
- ALU and LSU both valid for 4 cycles (regs 1 and 2 pending) -> grant order ALU, LSU, ALU, LSU; one commit per cycle; no bubbles.
- LSU commits addr 15 with data 32'h0000_0100 -> pc_load=1, pc_wdata=0x100, rf_we=0 for one cycle.
- Issue addr 5 twice -> the second attempt sees issue_ready=0 until the commit to 5 lands; then issue_ready=1 in the following cycle.
- ALU commits addr 7 with pending[7]=0 -> rf write happens, err_orphan=1 and stays 1 until rst. Then assert wb_stall with both valid -> both readies 0, no commits.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Round-robin between the ALU and LSU requesters. Writes to PC_REG are redirected
// to the PC load path. A pending-write scoreboard lets decode stall on RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_REG = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_stall,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [ADDR_W-1:0]      lsu_addr,
  input  logic [DATA_W-1:0]      lsu_data,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic                   issue_ready,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   pc_load,
  output logic [DATA_W-1:0]      pc_wdata,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   err_orphan
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  grant_t          last_grant;
  wb_req_t         commit_req;
  logic            commit_hs;
  logic            issue_hs;
  logic            orphan;
  logic [NREG-1:0] pending_nxt;

  // Round-robin grant: the requester that did not win last time takes a contended cycle.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!wb_stall) begin
      if (alu_valid && lsu_valid) begin
        alu_ready = (last_grant == GNT_LSU);
        lsu_ready = (last_grant == GNT_ALU);
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  // Select the winning payload; ready implies valid, so either ready is a handshake.
  always_comb begin
    commit_hs       = alu_ready || lsu_ready;
    commit_req.addr = alu_addr;
    commit_req.data = alu_data;
    if (lsu_ready) begin
      commit_req.addr = lsu_addr;
      commit_req.data = lsu_data;
    end
  end

  // Scoreboard next state: commit clears, issue sets, set wins on the same register.
  always_comb begin
    issue_ready = !pending[issue_addr];
    issue_hs    = issue_valid && issue_ready;
    orphan      = commit_hs && !pending[commit_req.addr];
    pending_nxt = pending;
    if (commit_hs) begin
      pending_nxt[commit_req.addr] = 1'b0;
    end
    if (issue_hs) begin
      pending_nxt[issue_addr] = 1'b1;
    end
  end

  // Registered commit outputs, grant pointer, scoreboard and sticky orphan flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_LSU;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      pc_load    <= 1'b0;
      pc_wdata   <= '0;
      pending    <= '0;
      err_orphan <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      pc_load <= 1'b0;
      if (commit_hs) begin
        last_grant <= lsu_ready ? GNT_LSU : GNT_ALU;
        if (commit_req.addr == PC_ADDR) begin
          pc_load  <= 1'b1;
          pc_wdata <= commit_req.data;
        end else begin
          rf_we    <= 1'b1;
          rf_waddr <= commit_req.addr;
          rf_wdata <= commit_req.data;
        end
      end
      pending <= pending_nxt;
      if (orphan) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of arbitration, routing and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_stall;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid, lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] issue_addr;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_load;
  logic [DATA_W-1:0] pc_wdata;
  logic [NREG-1:0]   pending;
  logic              err_orphan;

  int n_vec = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_REG(15)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_load(pc_load), .pc_wdata(pc_wdata), .pending(pending), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_pend[NREG];
  bit        m_last_lsu;
  bit        m_rf_we, m_pc_load, m_err;
  bit [3:0]  m_waddr;
  bit [31:0] m_wdata, m_pcdata;
  bit        m_alu_acc, m_lsu_acc;

  // Who may commit this cycle, as {alu, lsu}.
  function automatic logic [1:0] exp_ready();
    if (wb_stall) return 2'b00;
    if (alu_valid && lsu_valid) return m_last_lsu ? 2'b10 : 2'b01;
    return {alu_valid, lsu_valid};
  endfunction

  function automatic logic [NREG-1:0] m_pend_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [1:0]  g;
    logic [3:0]  a;
    logic [31:0] d;
    bit          iss_ok;
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      m_last_lsu = 1'b1;
      m_rf_we = 0; m_pc_load = 0; m_err = 0;
      m_waddr = '0; m_wdata = '0; m_pcdata = '0;
      m_alu_acc = 0; m_lsu_acc = 0;
    end else begin
      g = exp_ready();
      iss_ok = issue_valid && !m_pend[issue_addr];
      m_alu_acc = g[1];
      m_lsu_acc = g[0];
      m_rf_we = 0;
      m_pc_load = 0;
      if (g != 2'b00) begin
        a = g[1] ? alu_addr : lsu_addr;
        d = g[1] ? alu_data : lsu_data;
        m_last_lsu = g[0];
        if (a == 4'd15) begin
          m_pc_load = 1; m_pcdata = d;
        end else begin
          m_rf_we = 1; m_waddr = a; m_wdata = d;
        end
        if (!m_pend[a]) m_err = 1;
        m_pend[a] = 0;
      end
      if (iss_ok) m_pend[issue_addr] = 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [1:0] g;
    g = exp_ready();
    chk("alu_ready",   alu_ready,   g[1]);
    chk("lsu_ready",   lsu_ready,   g[0]);
    chk("issue_ready", issue_ready, !m_pend[issue_addr]);
    chk("rf_we",       rf_we,       m_rf_we);
    chk("rf_waddr",    rf_waddr,    m_waddr);
    chk("rf_wdata",    rf_wdata,    m_wdata);
    chk("pc_load",     pc_load,     m_pc_load);
    chk("pc_wdata",    pc_wdata,    m_pcdata);
    chk("pending",     pending,     m_pend_vec());
    chk("err_orphan",  err_orphan,  m_err);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a);
    issue_valid = 1; issue_addr = a;
    tick();
    issue_valid = 0;
  endtask

  function automatic logic [3:0] pick();
    logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) != 0)
      for (int k = 0; k < NREG; k++)
        if (m_pend[(int'(a) + k) % NREG]) return 4'((int'(a) + k) % NREG);
    return a;
  endfunction

  initial begin
    rst = 1; wb_stall = 0;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    lsu_valid = 0; lsu_addr = '0; lsu_data = '0;
    issue_valid = 0; issue_addr = '0;
    #3;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err_orphan, 0);
    tick(); tick();
    rst = 0;

    // Round robin under contention: ALU, LSU, ALU, LSU with no bubbles.
    issue(4'd1); issue(4'd2); issue(4'd4); issue(4'd6);
    chk("rr_pending", pending, 16'h0056);
    alu_valid = 1; alu_addr = 4'd1; alu_data = 32'hA1;
    lsu_valid = 1; lsu_addr = 4'd2; lsu_data = 32'hB2;
    #1;
    chk("rr0_alu_ready", alu_ready, 1);
    chk("rr0_lsu_ready", lsu_ready, 0);
    tick();
    chk("rr1_we", rf_we, 1); chk("rr1_addr", rf_waddr, 1); chk("rr1_data", rf_wdata, 32'hA1);
    alu_addr = 4'd4; alu_data = 32'hA4;
    #1;
    chk("rr1_lsu_ready", lsu_ready, 1);
    chk("rr1_alu_ready", alu_ready, 0);
    tick();
    chk("rr2_we", rf_we, 1); chk("rr2_addr", rf_waddr, 2); chk("rr2_data", rf_wdata, 32'hB2);
    lsu_addr = 4'd6; lsu_data = 32'hB6;
    #1;
    chk("rr2_alu_ready", alu_ready, 1);
    tick();
    chk("rr3_we", rf_we, 1); chk("rr3_addr", rf_waddr, 4);
    alu_valid = 0;
    tick();
    chk("rr4_we", rf_we, 1); chk("rr4_addr", rf_waddr, 6); chk("rr4_data", rf_wdata, 32'hB6);
    lsu_valid = 0;
    tick();
    chk("rr_idle_we", rf_we, 0);
    chk("rr_pending_clr", pending, 16'h0000);

    // Issue 3 then commit 3 from the ALU.
    issue(4'd3);
    chk("p3_set", pending[3], 1);
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
    #1;
    chk("c3_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    chk("c3_we", rf_we, 1); chk("c3_addr", rf_waddr, 3); chk("c3_data", rf_wdata, 32'hDEADBEEF);
    chk("c3_pc_load", pc_load, 0); chk("p3_clr", pending[3], 0);
    tick();
    chk("c3_we_drop", rf_we, 0); chk("c3_data_hold", rf_wdata, 32'hDEADBEEF);

    // LSU commit to R15 goes to the PC path.
    issue(4'd15);
    lsu_valid = 1; lsu_addr = 4'd15; lsu_data = 32'h0000_0100;
    tick();
    lsu_valid = 0;
    chk("pc_load", pc_load, 1); chk("pc_wdata", pc_wdata, 32'h100);
    chk("pc_rf_we", rf_we, 0); chk("pc_waddr_hold", rf_waddr, 3);
    tick();
    chk("pc_load_drop", pc_load, 0);

    // WAW stall on register 5.
    issue_valid = 1; issue_addr = 4'd5;
    tick();
    chk("waw_ready0", issue_ready, 0);
    tick();
    chk("waw_ready1", issue_ready, 0); chk("waw_p5", pending[5], 1);
    alu_valid = 1; alu_addr = 4'd5; alu_data = 32'h55;
    tick();
    alu_valid = 0;
    chk("waw_ready_back", issue_ready, 1); chk("waw_p5_clr", pending[5], 0);
    issue_valid = 0;
    tick();

    // Orphan commit to 7, then a stall with both requesters valid.
    alu_valid = 1; alu_addr = 4'd7; alu_data = 32'h77;
    tick();
    alu_valid = 0;
    chk("orph_we", rf_we, 1); chk("orph_addr", rf_waddr, 7); chk("orph_err", err_orphan, 1);
    repeat (3) tick();
    chk("orph_sticky", err_orphan, 1);
    wb_stall = 1; alu_valid = 1; alu_addr = 4'd1; lsu_valid = 1; lsu_addr = 4'd2;
    #1;
    chk("stall_alu_ready", alu_ready, 0); chk("stall_lsu_ready", lsu_ready, 0);
    repeat (3) begin
      tick();
      chk("stall_we", rf_we, 0); chk("stall_pc", pc_load, 0);
    end
    alu_valid = 0; lsu_valid = 0; wb_stall = 0;

    // Asynchronous reset while a commit is on the outputs.
    issue(4'd4); issue(4'd5); issue(4'd6); issue(4'd7);
    chk("pre_rst_pending", pending, 16'h00F0);
    alu_valid = 1; alu_addr = 4'd8; alu_data = 32'h88;
    tick();
    alu_valid = 0;
    chk("pre_rst_we", rf_we, 1); chk("pre_rst_pending2", pending, 16'h00F0);
    #2 rst = 1;
    #1;
    chk("arst_we", rf_we, 0); chk("arst_pc", pc_load, 0);
    chk("arst_pending", pending, 0); chk("arst_err", err_orphan, 0);
    tick(); tick();
    rst = 0;

    // Randomized traffic; requesters hold their payload until accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) begin
        alu_valid = 0; lsu_valid = 0; issue_valid = 0; wb_stall = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
      end
      if (!alu_valid || m_alu_acc) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr = pick(); alu_data = $urandom;
      end
      if (!lsu_valid || m_lsu_acc) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_addr = pick(); lsu_data = $urandom;
      end
      wb_stall    = ($urandom_range(0, 9) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = 4'($urandom_range(0, 15));
      tick();
    end
    alu_valid = 0; lsu_valid = 0; issue_valid = 0; wb_stall = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
